// File: rtl/neuro_pkg.sv
// Shared definitions for the neuromorphic datapath blocks.
//   NUM_CH_DEF      default number of spike channels
//   WINDOW_LOG2_DEF default log2 of the rate window length (enabled cycles)
//   CNT_W_DEF       default width of a per-channel rate count
//   sat_inc()       increment that sticks at a ceiling instead of wrapping
package neuro_pkg;

    localparam int NUM_CH_DEF      = 3;
    localparam int WINDOW_LOG2_DEF = 8;
    localparam int CNT_W_DEF       = 8;

    // Increment cnt by one, but never beyond max. Callers cast the result
    // back to their own counter width.
    function automatic logic [31:0] sat_inc(input logic [31:0] cnt,
                                            input logic [31:0] max);
        return (cnt >= max) ? max : cnt + 32'd1;
    endfunction

endpackage

// File: rtl/spike_rate_decoder_if.sv
// Snapshot hand-off between the spike rate decoder and its consumer.
//   rate_out   packed per-channel counts, channel i at [i*CNT_W +: CNT_W]
//   rate_valid snapshot available
//   rate_ready consumer accepts the snapshot when valid && ready
// Modports: master = decoder side, slave = consumer side.
interface spike_rate_decoder_if
    import neuro_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEF,
    parameter int CNT_W  = CNT_W_DEF
) ();

    logic [NUM_CH*CNT_W-1:0] rate_out;
    logic                    rate_valid;
    logic                    rate_ready;

    modport master (
        output rate_out,
        output rate_valid,
        input  rate_ready
    );

    modport slave (
        input  rate_out,
        input  rate_valid,
        output rate_ready
    );

endinterface

// File: rtl/spike_edge_counter.sv
// One spike channel: samples the line every cycle, detects rising edges and
// counts them with a saturating counter.
//   clk, rst_n   clock and asynchronous active-low reset
//   ena          count enable; history keeps sampling even when low
//   clr          restart the count (asserted on the last window cycle)
//   spike_in     spike line for this channel
//   cnt_closing  count including this cycle's edge; the value a window
//                closing on this cycle reports
module spike_edge_counter
    import neuro_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             clr,
    input  logic             spike_in,
    output logic [CNT_W-1:0] cnt_closing
);

    localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

    logic             hist_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic             rise_det;

    // A line held high only produces an edge on its first high sample.
    assign rise_det = spike_in & ~hist_reg;

    always_comb begin
        cnt_next = cnt_reg;
        if (rise_det) begin
            cnt_next = CNT_W'(sat_inc(32'(cnt_reg), CNT_MAX));
        end
    end

    // Edges on the closing cycle still belong to the closing window, so the
    // snapshot takes the updated value rather than the stored one.
    assign cnt_closing = cnt_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_reg <= 1'b0;
            cnt_reg  <= '0;
        end else begin
            // Sampled regardless of ena so re-enabling never sees a stale 0.
            hist_reg <= spike_in;
            if (ena) begin
                cnt_reg <= clr ? '0 : cnt_next;
            end
        end
    end

endmodule

// File: rtl/spike_rate_decoder.sv
// Spike rate decoder: counts rising edges per channel over a window of
// 2**WINDOW_LOG2 enabled cycles and offers each window's counts as one
// snapshot on a valid/ready interface.
//   clk, rst_n  clock and asynchronous active-low reset
//   ena         count enable; low freezes window position and counters
//   spike_in    spike lines, bit i = channel i
//   rate_if     snapshot interface (rate_out / rate_valid / rate_ready)
//   overrun     sticky flag: a completed window was dropped because the
//               previous snapshot was still waiting
module spike_rate_decoder
    import neuro_pkg::*;
#(
    parameter int NUM_CH      = NUM_CH_DEF,
    parameter int WINDOW_LOG2 = WINDOW_LOG2_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ena,
    input  logic [NUM_CH-1:0]   spike_in,
    spike_rate_decoder_if.master rate_if,
    output logic                overrun
);

    logic [WINDOW_LOG2-1:0]  win_cnt_reg;
    logic                    win_last;
    logic [NUM_CH*CNT_W-1:0] closing_counts;
    logic                    snap_load;
    logic                    xfer;

    logic [NUM_CH*CNT_W-1:0] rate_out_reg;
    logic [NUM_CH*CNT_W-1:0] rate_out_next;
    logic                    rate_valid_reg;
    logic                    rate_valid_next;
    logic                    overrun_reg;
    logic                    overrun_next;

    // Last window cycle: the enabled cycle where the position is all-ones.
    assign win_last = ena & (&win_cnt_reg);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            spike_edge_counter #(
                .CNT_W(CNT_W)
            ) u_cnt (
                .clk        (clk),
                .rst_n      (rst_n),
                .ena        (ena),
                .clr        (win_last),
                .spike_in   (spike_in[gi]),
                .cnt_closing(closing_counts[gi*CNT_W +: CNT_W])
            );
        end
    endgenerate

    assign xfer      = rate_valid_reg & rate_if.rate_ready;
    // A slot is free if empty or being emptied on this same edge.
    assign snap_load = win_last & (~rate_valid_reg | rate_if.rate_ready);

    always_comb begin
        rate_out_next   = rate_out_reg;
        rate_valid_next = rate_valid_reg;
        overrun_next    = overrun_reg;
        if (xfer) begin
            rate_valid_next = 1'b0;
        end
        if (snap_load) begin
            rate_out_next   = closing_counts;
            rate_valid_next = 1'b1;
        end
        if (win_last && rate_valid_reg && !rate_if.rate_ready) begin
            overrun_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_cnt_reg    <= '0;
            rate_out_reg   <= '0;
            rate_valid_reg <= 1'b0;
            overrun_reg    <= 1'b0;
        end else begin
            if (ena) begin
                win_cnt_reg <= win_cnt_reg + 1'b1;   // wraps naturally
            end
            rate_out_reg   <= rate_out_next;
            rate_valid_reg <= rate_valid_next;
            overrun_reg    <= overrun_next;
        end
    end

    assign rate_if.rate_out   = rate_out_reg;
    assign rate_if.rate_valid = rate_valid_reg;
    assign overrun            = overrun_reg;

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Self-checking bench for spike_rate_decoder with a window-level reference
// model: edges are tallied per window and clipped to the count ceiling when
// the window closes; snapshots follow the valid/ready rules.
module tb_spike_rate_decoder;

    localparam int NUM_CH = 3;
    localparam int WL     = 4;
    localparam int CW     = 3;
    localparam int WIN    = 1 << WL;
    localparam int CMAX   = (1 << CW) - 1;

    logic              clk      = 1'b0;
    logic              rst_n    = 1'b0;
    logic              ena      = 1'b0;
    logic [NUM_CH-1:0] spike_in = '0;
    logic              overrun;

    spike_rate_decoder_if #(.NUM_CH(NUM_CH), .CNT_W(CW)) rif ();

    spike_rate_decoder #(
        .NUM_CH     (NUM_CH),
        .WINDOW_LOG2(WL),
        .CNT_W      (CW)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .spike_in(spike_in),
        .rate_if (rif),
        .overrun (overrun)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int m_prev [NUM_CH];
    int m_acc  [NUM_CH];
    int m_rate [NUM_CH];
    int m_pos;
    int m_valid;
    int m_ovr;
    int valid_seen;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_prev[c] = 0;
            m_acc[c]  = 0;
            m_rate[c] = 0;
        end
        m_pos   = 0;
        m_valid = 0;
        m_ovr   = 0;
    endtask

    // One clock edge of the reference behaviour, using the inputs applied.
    task automatic model_step();
        int rdy;
        int closing [NUM_CH];
        int load;
        rdy  = int'(rif.rate_ready);
        load = 0;
        if (ena) begin
            for (int c = 0; c < NUM_CH; c++)
                if (spike_in[c] && m_prev[c] == 0) m_acc[c]++;
            m_pos++;
            if (m_pos == WIN) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    closing[c] = (m_acc[c] > CMAX) ? CMAX : m_acc[c];
                    m_acc[c]   = 0;
                end
                m_pos = 0;
                if (m_valid == 0 || rdy == 1) begin
                    load = 1;
                    for (int c = 0; c < NUM_CH; c++) m_rate[c] = closing[c];
                end else begin
                    m_ovr = 1;
                end
            end
        end
        if (load) m_valid = 1;
        else if (m_valid == 1 && rdy == 1) m_valid = 0;
        for (int c = 0; c < NUM_CH; c++) m_prev[c] = int'(spike_in[c]);
    endtask

    function automatic logic [31:0] exp_rate();
        logic [NUM_CH*CW-1:0] v;
        v = '0;
        for (int c = 0; c < NUM_CH; c++) v[c*CW +: CW] = CW'(m_rate[c]);
        return 32'(v);
    endfunction

    task automatic cycle(input logic e, input logic [NUM_CH-1:0] s, input logic r);
        ena            = e;
        spike_in       = s;
        rif.rate_ready = r;
        @(posedge clk);
        if (rst_n) model_step();
        else model_reset();
        @(negedge clk);
        if (rif.rate_valid) valid_seen++;
        check_val("rate_valid", 32'(rif.rate_valid), 32'(m_valid));
        check_val("overrun", 32'(overrun), 32'(m_ovr));
        check_val("rate_out", 32'(rif.rate_out), exp_rate());
    endtask

    initial begin
        logic [NUM_CH-1:0] rs;
        rif.rate_ready = 1'b1;
        model_reset();

        // Reset state
        repeat (2) @(negedge clk);
        check_val("reset_valid", 32'(rif.rate_valid), 32'd0);
        check_val("reset_rate", 32'(rif.rate_out), 32'd0);
        check_val("reset_ovr", 32'(overrun), 32'd0);
        rst_n = 1'b1;

        // 1: ch0 pulse every 4 cycles -> 4 per window, valid once per window
        valid_seen = 0;
        for (int i = 0; i < 4 * WIN; i++)
            cycle(1'b1, (i % 4 == 0) ? 3'b001 : 3'b000, 1'b1);
        check_val("valid_pulses", 32'(valid_seen), 32'd4);
        check_val("ch0_rate", 32'(rif.rate_out[0 +: CW]), 32'd4);

        // 2: ch1 held high for a whole window -> single edge
        for (int i = 0; i < 2 * WIN; i++) cycle(1'b1, 3'b010, 1'b1);
        cycle(1'b1, 3'b000, 1'b1);

        // 3: ch2 toggling -> 8 edges per window, saturates at 7
        for (int i = 0; i < 3 * WIN; i++) cycle(1'b1, (i % 2 == 0) ? 3'b100 : 3'b000, 1'b1);

        // 4: pulse exactly on the last window cycle
        while (m_pos != WIN - 1) cycle(1'b1, 3'b000, 1'b1);
        cycle(1'b1, 3'b001, 1'b1);
        check_val("last_cycle_pulse", 32'(rif.rate_out[0 +: CW]), 32'd1);
        for (int i = 0; i < WIN; i++) cycle(1'b1, 3'b000, 1'b1);
        check_val("after_last_pulse", 32'(rif.rate_out[0 +: CW]), 32'd0);

        // 5: consumer stalls for 40 cycles, then accepts on a close cycle
        for (int i = 0; i < 40; i++) cycle(1'b1, NUM_CH'($urandom_range(0, 7)), 1'b0);
        while (m_pos != WIN - 1) cycle(1'b1, NUM_CH'($urandom_range(0, 7)), 1'b0);
        cycle(1'b1, NUM_CH'($urandom_range(0, 7)), 1'b1);
        check_val("load_and_xfer_valid", 32'(rif.rate_valid), 32'd1);
        for (int i = 0; i < 5; i++) cycle(1'b1, NUM_CH'($urandom_range(0, 7)), 1'b1);

        // 6a: ena low for 10 cycles mid-window, spikes ignored
        while (m_pos != 5) cycle(1'b1, 3'b000, 1'b1);
        for (int i = 0; i < 10; i++) cycle(1'b0, (i % 2 == 0) ? 3'b111 : 3'b000, 1'b1);
        for (int i = 0; i < 2 * WIN; i++) cycle(1'b1, NUM_CH'($urandom_range(0, 7)), 1'b1);

        // 6b: asynchronous reset mid-window (overrun is set from step 5)
        while (m_pos != 7) cycle(1'b1, 3'b011, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check_val("async_rst_valid", 32'(rif.rate_valid), 32'd0);
        check_val("async_rst_rate", 32'(rif.rate_out), 32'd0);
        check_val("async_rst_ovr", 32'(overrun), 32'd0);
        cycle(1'b1, 3'b011, 1'b1);
        cycle(1'b1, 3'b000, 1'b1);
        rst_n = 1'b1;

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            rs = NUM_CH'($urandom_range(0, 7));
            cycle(($urandom_range(0, 9) != 0), rs, ($urandom_range(0, 3) != 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
